seg7_share_ctrl: RTL

- Time-shares the single 8-digit seven-segment display between four requesters, e.g. PC, ALU result, memory data and debug.
- Round-robin arbitration with a minimum on-screen hold time and a blank gap between owners.
- Drives the 32-bit nibble bus consumed by the seven-segment scan driver (nibble 0-9 = digit, 10 = '-', 15 = blank).

---
 rtl/seg7_share_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_share_ctrl: round-robin time-sharing of one 8-digit 7-seg display    |
// | among four requesters, with hold time and blank gap. Optional macro:      |
// | SEG7_OWNER_TAG_EN (leftmost digit shows owner, adds tag_valid output).    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module seg7_share_ctrl #(
  parameter logic [23:0] HOLD_CYCLES  = 24'd12_500_000,
  parameter logic [15:0] BLANK_CYCLES = 16'd1000,
  parameter int          CNT_W        = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] data,
  output logic [31:0]  x,
  output logic [3:0]   grant,
  output logic [1:0]   owner,
  output logic         busy
`ifdef SEG7_OWNER_TAG_EN
  ,
  output logic         tag_valid
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  localparam logic [31:0]      C_X_DASH     = 32'hAAAA_AAAA;
  localparam logic [31:0]      C_X_BLANK    = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] C_HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 24'd1);
  localparam logic [CNT_W-1:0] C_BLANK_LOAD = CNT_W'(BLANK_CYCLES - 16'd1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO   = '0;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_last;
  logic [1:0]       w_last_nxt;
  logic [1:0]       w_owner_nxt;
  logic [31:0]      w_x_nxt;
  logic [3:0]       w_grant_nxt;
  logic             w_busy_nxt;
  logic             w_pick_vld;
  logic [1:0]       w_pick_idx;
  logic [1:0]       w_try;
  logic [3:0]       w_owner_oh;
  logic             w_others;
  logic             w_owner_drop;
`ifdef SEG7_OWNER_TAG_EN
  logic             w_tag_nxt;
`endif

  // Scan last+4 down to last+1 so the nearest requester after last wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = r_last;
    w_try      = r_last;
    for (int k = 4; k >= 1; k--) begin
      w_try = r_last + 2'(k);
      if (req[w_try]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_try;
      end
    end
  end

  assign w_owner_oh   = 4'b0001 << owner;
  assign w_others     = |(req & ~w_owner_oh);
  assign w_owner_drop = ~req[owner];

  // State register, together with the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= C_CNT_ZERO;
      r_last    <= 2'd3;
      x         <= C_X_DASH;
      grant     <= 4'b0000;
      owner     <= 2'd0;
      busy      <= 1'b0;
`ifdef SEG7_OWNER_TAG_EN
      tag_valid <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      x         <= w_x_nxt;
      grant     <= w_grant_nxt;
      owner     <= w_owner_nxt;
      busy      <= w_busy_nxt;
`ifdef SEG7_OWNER_TAG_EN
      tag_valid <= w_tag_nxt;
`endif
    end
  end

  // Next-state logic; an owner dropping its request outranks the counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_owner_nxt = owner;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = C_HOLD_LOAD;
          w_last_nxt  = w_pick_idx;
          w_owner_nxt = w_pick_idx;
        end
      end
      S_HOLD: begin
        if (w_owner_drop) begin
          if (w_others) begin
            w_state_nxt = S_BLANK;
            w_cnt_nxt   = C_BLANK_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = C_CNT_ZERO;
          end
        end else if (r_cnt != C_CNT_ZERO) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_others) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = C_BLANK_LOAD;
        end else begin
          w_cnt_nxt = C_HOLD_LOAD;
        end
      end
      S_BLANK: begin
        if (r_cnt != C_CNT_ZERO) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_pick_vld) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = C_HOLD_LOAD;
          w_last_nxt  = w_pick_idx;
          w_owner_nxt = w_pick_idx;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = C_CNT_ZERO;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = C_CNT_ZERO;
      end
    endcase
  end

  // Output values for the upcoming state, registered on the same edge.
  always_comb begin
    w_x_nxt     = C_X_DASH;
    w_grant_nxt = 4'b0000;
    w_busy_nxt  = 1'b0;
`ifdef SEG7_OWNER_TAG_EN
    w_tag_nxt   = 1'b0;
`endif
    case (w_state_nxt)
      S_HOLD: begin
        w_x_nxt     = data[{w_owner_nxt, 5'd0} +: 32];
        w_grant_nxt = 4'b0001 << w_owner_nxt;
        w_busy_nxt  = 1'b1;
`ifdef SEG7_OWNER_TAG_EN
        w_x_nxt[31:28] = {2'b00, w_owner_nxt};
        w_tag_nxt      = 1'b1;
`endif
      end
      S_BLANK: begin
        w_x_nxt    = C_X_BLANK;
        w_busy_nxt = 1'b1;
      end
      default: begin
        w_x_nxt = C_X_DASH;
      end
    endcase
  end

endmodule
`default_nettype wire
